// File: rtl/up_down_load_counter.sv
// Loadable, enable-gated up/down counter with registered one-cycle overflow/underflow pulses.
// Define UDC_SATURATE_EN to saturate at the limits instead of wrapping.
module up_down_load_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_up_down,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    output logic [WIDTH-1:0] o_count,
    output logic             o_ovf,
    output logic             o_udf
);

    localparam logic [WIDTH-1:0] MaxCount = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] OneCount = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             r_udf;

    logic [WIDTH-1:0] w_count;
    logic             w_ovf;
    logic             w_udf;

    always_comb begin
        w_count = r_count;
        w_ovf   = 1'b0;
        w_udf   = 1'b0;
        if (i_load) begin
            w_count = i_load_data;
        end else if (i_en) begin
            if (i_up_down) begin
                if (r_count == MaxCount) begin
                    w_ovf = 1'b1;
`ifdef UDC_SATURATE_EN
                    w_count = MaxCount;
`else
                    w_count = '0;
`endif
                end else begin
                    w_count = r_count + OneCount;
                end
            end else begin
                if (r_count == '0) begin
                    w_udf = 1'b1;
`ifdef UDC_SATURATE_EN
                    w_count = '0;
`else
                    w_count = MaxCount;
`endif
                end else begin
                    w_count = r_count - OneCount;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_count <= w_count;
            r_ovf   <= w_ovf;
            r_udf   <= w_udf;
        end
    end

    assign o_count = r_count;
    assign o_ovf   = r_ovf;
    assign o_udf   = r_udf;

endmodule

// File: tb/tb_up_down_load_counter.sv
// Randomized self-checking bench for up_down_load_counter against an arithmetic reference model.
module tb_up_down_load_counter;

    localparam int W   = 8;
    localparam int MOD = 1 << W;
`ifdef UDC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         up_down;
    logic         load;
    logic [W-1:0] load_data;
    logic [W-1:0] count;
    logic         ovf;
    logic         udf;

    int n_checks = 0;
    int n_pass   = 0;

    int m_count = 0;
    bit m_ovf   = 1'b0;
    bit m_udf   = 1'b0;

    always #5 clk = ~clk;

    up_down_load_counter #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_up_down   (up_down),
        .i_load      (load),
        .i_load_data (load_data),
        .o_count     (count),
        .o_ovf       (ovf),
        .o_udf       (udf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Next state from plain integer arithmetic: step, then detect leaving [0, MOD).
    task automatic model_step(input bit ld, input int d, input bit e, input bit up);
        int nxt;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        if (ld) begin
            m_count = d;
        end else if (e) begin
            nxt = up ? m_count + 1 : m_count - 1;
            if (nxt >= MOD) begin
                m_ovf   = 1'b1;
                m_count = SAT ? MOD - 1 : nxt - MOD;
            end else if (nxt < 0) begin
                m_udf   = 1'b1;
                m_count = SAT ? 0 : nxt + MOD;
            end else begin
                m_count = nxt;
            end
        end
    endtask

    // Called at #1 after a rising edge: drive, advance one edge, compare.
    task automatic step(input bit ld, input logic [W-1:0] d, input bit e, input bit up);
        load      = ld;
        load_data = d;
        en        = e;
        up_down   = up;
        @(posedge clk);
        #1;
        model_step(ld, int'(d), e, up);
        check("count", 32'(count), 32'(m_count));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("udf", 32'(udf), 32'(m_udf));
        check("flag_excl", 32'(ovf & udf), 32'd0);
    endtask

    initial begin
        int pick;
        logic [W-1:0] d;
        rst_n = 1'b0; en = 1'b0; up_down = 1'b0; load = 1'b0; load_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_count", 32'(count), 32'h00);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_udf", 32'(udf), 32'd0);

        // Up-count from 0, then hold.
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, '0, 1'b1, 1'b1);
            check("up_seq", 32'(count), 32'(i));
        end
        step(1'b0, '0, 1'b0, 1'b1);
        check("hold", 32'(count), 32'd5);

        // Overflow around max.
        step(1'b1, 8'hFE, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        check("ovf_c1", 32'(count), 32'hFF);
        check("ovf_f1", 32'(ovf), 32'd0);
        step(1'b0, '0, 1'b1, 1'b1);
        check("ovf_c2", 32'(count), SAT ? 32'hFF : 32'h00);
        check("ovf_f2", 32'(ovf), 32'd1);
        step(1'b0, '0, 1'b1, 1'b1);
        check("ovf_c3", 32'(count), SAT ? 32'hFF : 32'h01);
        check("ovf_f3", 32'(ovf), SAT ? 32'd1 : 32'd0);

        // Underflow around 0.
        step(1'b1, 8'h01, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("udf_c1", 32'(count), 32'h00);
        step(1'b0, '0, 1'b1, 1'b0);
        check("udf_c2", 32'(count), SAT ? 32'h00 : 32'hFF);
        check("udf_f2", 32'(udf), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("udf_c3", 32'(count), SAT ? 32'h00 : 32'hFE);
        check("udf_f3", 32'(udf), SAT ? 32'd1 : 32'd0);

        // Load beats enable.
        step(1'b1, 8'hA5, 1'b1, 1'b1);
        check("load_prio", 32'(count), 32'hA5);

        // Load max then count up.
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        check("max_up_ovf", 32'(ovf), 32'd1);

        // Direction toggle.
        step(1'b1, 8'h10, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, (i % 2) == 0);
            check("toggle", 32'(count), (i % 2) == 0 ? 32'h11 : 32'h10);
        end

        // Asynchronous reset mid-count at 0x37.
        step(1'b1, 8'h36, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        check("pre_arst", 32'(count), 32'h37);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'h00);
        check("arst_flags", 32'({ovf, udf}), 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_count = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;

        // Random traffic, biased toward the limits so wraps actually occur.
        for (int i = 0; i < 600; i++) begin
            pick = int'($urandom_range(0, 9));
            case (pick)
                0:       d = 8'h00;
                1:       d = 8'h01;
                2:       d = 8'hFE;
                3:       d = 8'hFF;
                default: d = W'($urandom);
            endcase
            step($urandom_range(0, 7) == 0, d, $urandom_range(0, 3) != 0, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/up_down_load_counter.md
Name: up_down_load_counter

Overview:
- Synchronous, loadable, enable-gated up/down binary counter with registered one-cycle overflow and underflow flags.
- Used as a generic event/position counter in the datapath.
- Drives its count and flags directly from registers, so downstream logic gets clean, glitch-free outputs.

Parameters:
- WIDTH, 8, bit width of i_load_data and o_count (legal range 2..32).

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  count enable; when 1 the counter steps by one each cycle.
- i_up_down  input  1  direction: 1 = count up, 0 = count down.
- i_load  input  1  synchronous load strobe; takes priority over i_en.
- i_load_data  input  WIDTH  value loaded when i_load = 1.
- o_count  output  WIDTH  registered counter value.
- o_ovf  output  1  registered one-cycle pulse: up-count wrapped from max to 0.
- o_udf  output  1  registered one-cycle pulse: down-count wrapped from 0 to max.

Behaviour:
- Interface: one clock, i_clk, rising edge; reset i_rst_n is asynchronous and active-low.
- Reset (i_rst_n = 0, any time, including mid-operation): o_count = 0, o_ovf = 0, o_udf = 0 immediately, without waiting for a clock.
- After reset deasserts, the first active edge evaluates the inputs normally.
- Per-edge priority, highest first:
  - i_load = 1: o_count <= i_load_data. o_ovf <= 0, o_udf <= 0. Applies regardless of i_en and i_up_down.
  - i_en = 1, i_up_down = 1: o_count <= o_count + 1 modulo 2^WIDTH. o_ovf <= 1 only if old o_count = 2^WIDTH-1, else 0. o_udf <= 0.
  - i_en = 1, i_up_down = 0: o_count <= o_count - 1 modulo 2^WIDTH. o_udf <= 1 only if old o_count = 0, else 0. o_ovf <= 0.
  - i_en = 0: o_count holds; o_ovf <= 0, o_udf <= 0.
- Latency: o_count and the flags reflect the inputs one clock after sampling.
- Flags are high for exactly one cycle per wrap event; they are never both high together.
- Continuous up-counting from max-1 gives: max (ovf 0), then 0 (ovf 1), then 1 (ovf 0).
- Direction may change on any cycle; the new direction applies to that edge.
- Loading the value max, then counting up with i_en = 1 gives o_count = 0 and o_ovf = 1 on the next edge.
- Inputs are sampled only on rising i_clk; there is no combinational path from any input to any output.
- X on i_load_data is ignored unless i_load = 1.

Optional Feature:
- Macro UDC_SATURATE_EN.
- Defined: the counter saturates instead of wrapping.
  - Up-count at max holds max and pulses o_ovf for one cycle.
  - Down-count at 0 holds 0 and pulses o_udf for one cycle.
  - The flag re-pulses on every enabled cycle that attempts to pass the limit.
- Undefined (default): modulo wrap-around as described in Behaviour.
- Load, reset and hold behaviour are identical in both builds.

Test Plan:
- Reset: hold i_rst_n = 0 for 2 clocks with all inputs 0, then release -> o_count = 0x00, o_ovf = 0, o_udf = 0. Assert i_rst_n mid-count at o_count = 0x37 -> outputs 0 immediately, asynchronously.
- Up-count: i_en = 1, i_up_down = 1 for 5 cycles from 0 -> o_count = 1, 2, 3, 4, 5, flags 0. Drop i_en -> o_count holds 5.
- Overflow: load 0xFE, then count up 3 cycles -> 0xFF (ovf 0), 0x00 (ovf 1), 0x01 (ovf 0). With UDC_SATURATE_EN -> 0xFF, 0xFF (ovf 1), 0xFF (ovf 1).
- Underflow: load 0x01, then count down 3 cycles -> 0x00 (udf 0), 0xFF (udf 1), 0xFE (udf 0).
- Load priority: i_load = 1, i_load_data = 0xA5, i_en = 1, i_up_down = 1 -> o_count = 0xA5 next cycle, flags 0.
- Direction toggle: from 0x10, alternate i_up_down each cycle with i_en = 1 -> 0x11, 0x10, 0x11, 0x10; no flags asserted.
